spi_adc_responder: RTL
======================

SPI_ADC_RESPONDER -- requirements
Module: spi_adc_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 18, bits per SPI frame and holding-register width.
REQ-002 Parameter SYNC_STAGES, default 2, flip-flop stages on cs_n and sclk inputs (minimum 2).
REQ-003 clk  input  1  system clock, 100 MHz nominal; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cs_n  input  1  SPI chip select from master, active-low, asynchronous to clk.
REQ-006 sclk  input  1  SPI clock from master, CPOL=0, at most clk/8, asynchronous to clk.
REQ-007 miso  output  1  serial data to master, MSB first, always driven (no tri-state).
REQ-008 sample_in  input  DATA_WIDTH  parallel sample to be served in the next frame.
REQ-009 sample_wr  input  1  single-cycle strobe; writes sample_in into holding register.
REQ-010 sample_full  output  1  high while holding register contains an unserved sample.
REQ-011 frame_done  output  1  one-cycle pulse after DATA_WIDTH bits clocked out with cs_n still low.
REQ-012 frame_abort  output  1  one-cycle pulse when cs_n deasserts before DATA_WIDTH rising sclk edges.
REQ-013 overrun  output  1  one-cycle pulse when sample_wr arrives while sample_full=1 with no load that cycle.
REQ-014 underrun  output  1  one-cycle pulse when a frame starts while sample_full=0.

Function
REQ-015 cs_n and sclk SHALL each pass through SYNC_STAGES flops; edges detected from last stage against a delayed copy.
REQ-016 FSM states SHALL be IDLE, LOAD, SHIFT, DONE.
REQ-017 IDLE: miso=0; on synchronized cs_n falling edge go to LOAD.
REQ-018 LOAD (one cycle): shift register <= holding register if sample_full else all zeros; sample_full cleared; underrun pulses if empty; bit counter <= 0; go to SHIFT.
REQ-019 SHIFT: miso SHALL equal shift register MSB; MSB valid no later than SYNC_STAGES+2 clk cycles after cs_n falls.
REQ-020 SHIFT: each synchronized sclk rising edge increments bit counter (master samples on this edge).
REQ-021 SHIFT: each synchronized sclk falling edge shifts register left by one, LSB filled with 0, only if bit counter < DATA_WIDTH.
REQ-022 SHIFT: when bit counter reaches DATA_WIDTH go to DONE; further sclk edges while cs_n low SHALL drive miso=0 and not change state.
REQ-023 DONE: wait for cs_n rising edge; then frame_done pulses one cycle and FSM returns to IDLE.
REQ-024 cs_n rising edge in LOAD or SHIFT with bit counter < DATA_WIDTH: frame_abort pulses, no frame_done, FSM to IDLE, consumed sample not restored.
REQ-025 sample_wr in any state SHALL load holding register and set sample_full the next cycle.
REQ-026 sample_wr in the same cycle as LOAD: LOAD takes the old holding value, then holding register takes new sample_in and sample_full stays 1; no overrun.
REQ-027 sample_wr with sample_full=1 outside LOAD: new value overwrites, overrun pulses.
REQ-028 Bit counter width SHALL be clog2(DATA_WIDTH+1); no wrap within a frame.
REQ-029 sclk edges while cs_n high SHALL be ignored.

Reset
REQ-030 While reset=1: state IDLE, miso=0, sample_full=0, frame_done=0, frame_abort=0, overrun=0, underrun=0, shift register, holding register, counter and synchronizers all 0.
REQ-031 Reset asserted mid-frame SHALL abort without frame_abort pulse; after release, FSM waits for a new cs_n falling edge (cs_n already low at release is not a frame start).

Verification
REQ-032 Write 18'h2A5C3, then 18 sclk cycles at clk/10 with cs_n low -> master captures 18'h2A5C3 on rising edges, frame_done once after cs_n rises, sample_full 1->0.
REQ-033 Frame with sample_full=0 -> underrun pulse, master captures 18'h00000, frame_done pulses.
REQ-034 Write 18'h3FFFF, cs_n high after 7 rising edges -> frame_abort pulse, no frame_done, next frame without write gives underrun and 18'h00000.
REQ-035 Write 18'h11111 then 18'h22222 before frame -> overrun pulse on second write, frame returns 18'h22222.
REQ-036 sample_wr of 18'h0ABCD coincident with LOAD of 18'h12345 -> frame returns 18'h12345, sample_full=1 after, next frame returns 18'h0ABCD.
REQ-037 Assert reset during bit 9 with cs_n held low, release, then 22 sclk cycles -> miso=0 throughout, no pulses; next full cs_n frame operates normally.

Source files
------------

// File: rtl/spi_adc_responder_if.sv
// rtl/spi_adc_responder_if.sv - SPI link and sample-load signals of the ADC responder
interface spi_adc_responder_if #(
    parameter int DATA_WIDTH = 18
);
    logic                  cs_n;
    logic                  sclk;
    logic                  miso;
    logic [DATA_WIDTH-1:0] sample_in;
    logic                  sample_wr;
    logic                  sample_full;
    logic                  frame_done;
    logic                  frame_abort;
    logic                  overrun;
    logic                  underrun;

    modport master (
        output cs_n, sclk, sample_in, sample_wr,
        input  miso, sample_full, frame_done, frame_abort, overrun, underrun
    );

    modport slave (
        input  cs_n, sclk, sample_in, sample_wr,
        output miso, sample_full, frame_done, frame_abort, overrun, underrun
    );
endinterface

// File: rtl/spi_adc_responder.sv
// rtl/spi_adc_responder.sv - SPI slave that serves one held ADC sample per cs_n frame, MSB first
module spi_adc_responder #(
    parameter int DATA_WIDTH  = 18,
    parameter int SYNC_STAGES = 2
) (
    input logic               clk,
    input logic               reset,
    spi_adc_responder_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic                   cs_dly_q, cs_dly_d;
    logic                   sclk_dly_q, sclk_dly_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [DATA_WIDTH-1:0]  hold_q, hold_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   full_q, full_d;
    logic                   done_q, done_d;
    logic                   abort_q, abort_d;
    logic                   overrun_q, overrun_d;
    logic                   underrun_q, underrun_d;

    logic cs_s, sclk_s;
    logic cs_fall, cs_rise, sclk_rise, sclk_fall;

    // Synchronizers reset to 0, so cs_n already low at release never looks like a falling edge.
    always_comb begin
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        cs_dly_d    = cs_s;
        sclk_dly_d  = sclk_s;
        cs_fall     = cs_dly_q & ~cs_s;
        cs_rise     = ~cs_dly_q & cs_s;
        sclk_rise   = ~sclk_dly_q & sclk_s & ~cs_s;
        sclk_fall   = sclk_dly_q & ~sclk_s & ~cs_s;
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        cnt_d      = cnt_q;
        full_d     = full_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        overrun_d  = 1'b0;
        underrun_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cs_fall) state_d = LOAD;
            end
            LOAD: begin
                shift_d    = full_q ? hold_q : '0;
                underrun_d = ~full_q;
                full_d     = 1'b0;
                cnt_d      = '0;
                if (cs_rise) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    if (sclk_rise) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q + 1'b1 == CNT_MAX) state_d = DONE;
                    end
                    if (sclk_fall && cnt_q < CNT_MAX) begin
                        shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            DONE: begin
                if (cs_rise) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A write in the LOAD cycle lands after the load, so it refills rather than overruns.
        if (bus.sample_wr) begin
            hold_d    = bus.sample_in;
            full_d    = 1'b1;
            overrun_d = full_q && (state_q != LOAD);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cs_sync_q   <= '0;
            sclk_sync_q <= '0;
            cs_dly_q    <= 1'b0;
            sclk_dly_q  <= 1'b0;
            shift_q     <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cs_sync_q   <= cs_sync_d;
            sclk_sync_q <= sclk_sync_d;
            cs_dly_q    <= cs_dly_d;
            sclk_dly_q  <= sclk_dly_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
        end
    end

    assign bus.miso        = (state_q == SHIFT) ? shift_q[DATA_WIDTH-1] : 1'b0;
    assign bus.sample_full = full_q;
    assign bus.frame_done  = done_q;
    assign bus.frame_abort = abort_q;
    assign bus.overrun     = overrun_q;
    assign bus.underrun    = underrun_q;
endmodule
